// File: rtl/ili9341_spi_receiver.sv
// rtl/ili9341_spi_receiver.sv - SPI byte receiver for ILI9341-style command/data streams with a receive FIFO
module ili9341_spi_receiver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs,
    input  logic       spi_dc,
    input  logic       spi_din,
    input  logic       rd_en,
    output logic [8:0] rd_data,
    output logic       fifo_empty,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic       frame_error,
    output logic [7:0] cmd_count
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, dc_sync, din_sync;
    logic                   sclk_prev;
    logic                   sclk_s, cs_s, dc_s, din_s, sclk_rise;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic       push, frame_set;
    logic [8:0] push_data;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          full, pop, wr_ok;

    // All four pins share one synchroniser depth so dc/din stay aligned with sclk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            dc_sync   <= '0;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], spi_din};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 7'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Only seven bits are held; the eighth goes straight into the FIFO on the same edge
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_s) state_d = SHIFT;
            end
            SHIFT: begin
                if (cs_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    frame_set = (bit_cnt_q != 3'd0);
                end else if (sclk_rise) begin
                    shreg_d   = {shreg_q[5:0], din_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    push      = (bit_cnt_q == 3'd7);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_data = {dc_s, shreg_q, din_s};

    assign full  = (count == DEPTH_L);
    assign pop   = rd_en && (count != 5'd0);
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= 5'd0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
            cmd_count   <= 8'd0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            if (frame_set) frame_error <= 1'b1;
            if (wr_ok && !dc_s) cmd_count <= cmd_count + 8'd1;
        end
    end

    assign rd_data    = mem[rd_ptr];
    assign fifo_empty = (count == 5'd0);
    assign fifo_count = count;

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// tb/tb_ili9341_spi_receiver.sv - scoreboard bench for ili9341_spi_receiver
module tb_ili9341_spi_receiver;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_dc = 1'b0;
    logic       spi_din = 1'b0;
    logic       rd_en = 1'b0;
    logic [8:0] rd_data;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       frame_error;
    logic [7:0] cmd_count;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    ili9341_spi_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
        .spi_dc(spi_dc), .spi_din(spi_din), .rd_en(rd_en), .rd_data(rd_data),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .overflow(overflow),
        .frame_error(frame_error), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // Pops happen on the posedge following this negedge
    always @(negedge clk) begin
        if (!rst && rd_en && !fifo_empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data_unexpected actual=%h required=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data actual=%h required=%h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic d, input bit last,
                            input bit pop_at_push, input bit chk_lat);
        spi_din = b;
        spi_dc  = d;
        tick(4);
        spi_sclk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            if (last) begin
                if (pop_at_push && k == SYNC)     rd_en = 1'b1;
                if (pop_at_push && k == SYNC + 1) rd_en = 1'b0;
                if (chk_lat && k == SYNC)     check("empty_before_push", fifo_empty, 1);
                if (chk_lat && k == SYNC + 1) check("empty_at_push", fifo_empty, 0);
            end
        end
        spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input bit accept,
                             input bit pop_at_push, input bit chk_lat);
        if (accept) exp_q.push_back({d, b});
        for (int i = 7; i >= 0; i--)
            send_bit(b[i], d, i == 0, pop_at_push, chk_lat);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(2);
        spi_cs = 1'b1;
        tick(SYNC + 4);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            rd_en = 1'b1;
            tick(1);
            rd_en = 1'b0;
            tick(1);
        end
    endtask

    task automatic do_reset();
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        rd_en    = 1'b0;
        rst      = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_empty"}, fifo_empty, 1);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_frame_error"}, frame_error, 0);
        check({tag, "_cmd_count"}, cmd_count, 0);
    endtask

    initial begin
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(2);

        // single command byte with latency check
        cs_low();
        send_byte(8'h11, 1'b0, 1, 0, 1);
        check("s1_count", fifo_count, 1);
        check("s1_cmd_count", cmd_count, 1);
        cs_high();
        drain(1);
        check("s1_empty_after_read", fifo_empty, 1);

        // back-to-back bytes in one burst
        do_reset();
        cs_low();
        send_byte(8'h3A, 1'b0, 1, 0, 0);
        send_byte(8'h55, 1'b1, 1, 0, 0);
        cs_high();
        check("s2_count", fifo_count, 2);
        check("s2_cmd_count", cmd_count, 1);
        drain(2);

        // partial byte then a full one
        do_reset();
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b1, 0, 0, 0);
        cs_high();
        check("s3_frame_error", frame_error, 1);
        check("s3_count_after_abort", fifo_count, 0);
        cs_low();
        send_byte(8'hA5, 1'b1, 1, 0, 0);
        cs_high();
        check("s3_count", fifo_count, 1);
        check("s3_frame_error_sticky", frame_error, 1);
        drain(1);

        // overflow
        do_reset();
        cs_low();
        for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b1, v <= DEPTH, 0, 0);
        cs_high();
        check("s4_count", fifo_count, DEPTH);
        check("s4_overflow", overflow, 1);
        check("s4_cmd_count", cmd_count, 0);
        drain(DEPTH);
        check("s4_empty", fifo_empty, 1);
        drain(1);
        check("s4_no_underflow", fifo_count, 0);

        // simultaneous push and pop while full
        do_reset();
        cs_low();
        for (int v = 8'h61; v <= 8'h64; v++) send_byte(8'(v), 1'b1, 1, 0, 0);
        check("s5_full", fifo_count, DEPTH);
        send_byte(8'h66, 1'b1, 1, 1, 0);
        check("s5_count", fifo_count, DEPTH);
        check("s5_overflow", overflow, 0);
        cs_high();
        drain(DEPTH);
        check("s5_empty", fifo_empty, 1);

        // reset mid-byte
        do_reset();
        cs_low();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0, 0, 0);
        rst = 1'b1;
        tick(1);
        check_reset_values("s6_rst");
        tick(2);
        rst = 1'b0;
        tick(2);
        send_byte(8'hC3, 1'b0, 1, 0, 0);
        cs_high();
        check("s6_count", fifo_count, 1);
        check("s6_cmd_count", cmd_count, 1);
        check("s6_frame_error", frame_error, 0);
        drain(1);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
